// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: centre-button FSM states
// and the index of each direction button inside the direction vectors.
// Imported by the top level.
package button_pkg;

    typedef enum logic [1:0] {
        C_IDLE      = 2'd0,
        C_HELD      = 2'd1,
        C_LONG_DONE = 2'd2
    } c_state_t;

    localparam int DIR_U = 0;
    localparam int DIR_D = 1;
    localparam int DIR_L = 2;
    localparam int DIR_R = 3;

    localparam int NUM_DIRS = 4;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, then a debounce counter that accepts a
// level change after DEBOUNCE_CYCLES consecutive differing samples.
// rise_o/fall_o are one-cycle pulses, registered together with stable_o.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous pin level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing samples; flip the stable level on the last one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            stable_o <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (sync_q2 != stable_o) begin
                if (cnt == CNT_LAST) begin
                    stable_o <= sync_q2;
                    cnt      <= '0;
                    rise_o   <= sync_q2;
                    fall_o   <= !sync_q2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Turns five raw push-buttons into one-hot single-cycle game commands
// (centre short/long, u/d/l/r); direction pulse DEBOUNCE_CYCLES+3 after a raw rise.
// No backpressure: losing directions stay pending; BUTTON_AUTOREPEAT_EN adds held-direction repeat.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int LONG_PRESS_CYCLES    = 50_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 40_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 15_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_c_raw,
    input  logic       btn_u_raw,
    input  logic       btn_d_raw,
    input  logic       btn_l_raw,
    input  logic       btn_r_raw,
    output logic       button_c_short,
    output logic       button_c_long,
    output logic       button_u,
    output logic       button_d,
    output logic       button_l,
    output logic       button_r,
    output logic [4:0] btn_level_o
);

    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    // Button vectors use the level-output order {c,u,d,l,r}.
    logic [4:0] raw_vec;
    logic [4:0] stable_vec;
    logic [4:0] rise_vec;
    logic [4:0] fall_vec;

    assign raw_vec = {btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw};

    for (genvar i = 0; i < 5; i++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw     (raw_vec[i]),
            .stable_o(stable_vec[i]),
            .rise_o  (rise_vec[i]),
            .fall_o  (fall_vec[i])
        );
    end

    assign btn_level_o = stable_vec;

    // Direction falls carry no command; only the centre uses its fall.
    logic unused_dir_falls;
    assign unused_dir_falls = ^fall_vec[3:0];

    logic                c_rise;
    logic                c_fall;
    logic [NUM_DIRS-1:0] dir_rise;
    logic [NUM_DIRS-1:0] dir_stable;

    assign c_rise = rise_vec[4];
    assign c_fall = fall_vec[4];

    assign dir_rise[DIR_U]   = rise_vec[3];
    assign dir_rise[DIR_D]   = rise_vec[2];
    assign dir_rise[DIR_L]   = rise_vec[1];
    assign dir_rise[DIR_R]   = rise_vec[0];
    assign dir_stable[DIR_U] = stable_vec[3];
    assign dir_stable[DIR_D] = stable_vec[2];
    assign dir_stable[DIR_L] = stable_vec[1];
    assign dir_stable[DIR_R] = stable_vec[0];

    // ---------------------------------------------------------------
    // Centre button classification
    // ---------------------------------------------------------------
    c_state_t      c_state;
    logic [HW-1:0] hold_cnt;
    logic          hold_last;
    logic          c_short_req;
    logic          c_long_req;

    // Requests are decoded from the current state so the arbiter register
    // is the only stage between the FSM and the output pins.
    always_comb begin
        hold_last   = (hold_cnt == HOLD_LAST);
        c_long_req  = (c_state == C_HELD) && hold_last;
        c_short_req = (c_state == C_HELD) && c_fall && !hold_last;
    end

    // Centre FSM: track how long the debounced centre level stays high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_state  <= C_IDLE;
            hold_cnt <= '0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (c_rise) begin
                        c_state  <= C_HELD;
                        hold_cnt <= '0;
                    end
                end
                C_HELD: begin
                    if (hold_last) begin
                        // A release landing on the long-press cycle still
                        // counts as long; go straight to idle so it is not lost.
                        c_state <= c_fall ? C_IDLE : C_LONG_DONE;
                    end else if (c_fall) begin
                        c_state <= C_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                C_LONG_DONE: begin
                    if (c_fall) begin
                        c_state <= C_IDLE;
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Direction request sources
    // ---------------------------------------------------------------
    logic [NUM_DIRS-1:0] dir_set;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

    logic [RW-1:0]       rpt_cnt [NUM_DIRS];
    logic [NUM_DIRS-1:0] rpt_phase;
    logic [NUM_DIRS-1:0] rpt_req;

    // First repeat waits the delay, later ones the period (rpt_phase set).
    always_comb begin
        for (int d = 0; d < NUM_DIRS; d++) begin
            rpt_req[d] = dir_stable[d] &&
                         (rpt_cnt[d] == (rpt_phase[d] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    // Repeat counters run while a direction is held and clear on release.
    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (!rst || !dir_stable[d]) begin
                rpt_cnt[d]   <= '0;
                rpt_phase[d] <= 1'b0;
            end else if (rpt_req[d]) begin
                rpt_cnt[d]   <= '0;
                rpt_phase[d] <= 1'b1;
            end else begin
                rpt_cnt[d] <= rpt_cnt[d] + RW'(1);
            end
        end
    end

    assign dir_set = dir_rise | rpt_req;
`else
    localparam int unused_rpt_cfg = REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES;

    assign dir_set = dir_rise;
`endif

    // ---------------------------------------------------------------
    // Pending bits and output arbiter
    // ---------------------------------------------------------------
    logic [NUM_DIRS-1:0] pending;
    logic [NUM_DIRS-1:0] pend_all;
    logic [NUM_DIRS-1:0] pend_next;
    logic [NUM_DIRS-1:0] dir_next;
    logic [NUM_DIRS-1:0] dir_pulse;
    logic                short_next;
    logic                long_next;

    // Centre always wins; otherwise issue one direction in u>d>l>r order.
    always_comb begin
        pend_all   = pending | dir_set;
        pend_next  = pend_all;
        dir_next   = '0;
        short_next = 1'b0;
        long_next  = 1'b0;
        if (c_short_req || c_long_req) begin
            short_next = c_short_req;
            long_next  = c_long_req;
        end else if (pend_all[DIR_U]) begin
            dir_next[DIR_U]  = 1'b1;
            pend_next[DIR_U] = 1'b0;
        end else if (pend_all[DIR_D]) begin
            dir_next[DIR_D]  = 1'b1;
            pend_next[DIR_D] = 1'b0;
        end else if (pend_all[DIR_L]) begin
            dir_next[DIR_L]  = 1'b1;
            pend_next[DIR_L] = 1'b0;
        end else if (pend_all[DIR_R]) begin
            dir_next[DIR_R]  = 1'b1;
            pend_next[DIR_R] = 1'b0;
        end
    end

    // Register the chosen command and the surviving pending bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending        <= '0;
            dir_pulse      <= '0;
            button_c_short <= 1'b0;
            button_c_long  <= 1'b0;
        end else begin
            pending        <= pend_next;
            dir_pulse      <= dir_next;
            button_c_short <= short_next;
            button_c_long  <= long_next;
        end
    end

    assign button_u = dir_pulse[DIR_U];
    assign button_d = dir_pulse[DIR_D];
    assign button_l = dir_pulse[DIR_L];
    assign button_r = dir_pulse[DIR_R];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Each scenario records the command outputs per cycle and checks exact edges.
// Expectations switch on BUTTON_AUTOREPEAT_EN to match the build.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int LP = 20;
    localparam int RD = 30;
    localparam int RP = 10;

    localparam logic [5:0] P_SHORT = 6'b100000;
    localparam logic [5:0] P_LONG  = 6'b010000;
    localparam logic [5:0] P_U     = 6'b001000;
    localparam logic [5:0] P_L     = 6'b000010;
    localparam logic [5:0] P_R     = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_c_raw = 1'b0;
    logic       btn_u_raw = 1'b0;
    logic       btn_d_raw = 1'b0;
    logic       btn_l_raw = 1'b0;
    logic       btn_r_raw = 1'b0;
    logic       button_c_short;
    logic       button_c_long;
    logic       button_u;
    logic       button_d;
    logic       button_l;
    logic       button_r;
    logic [4:0] btn_level_o;

    int vectors     = 0;
    int miscompares = 0;
    int onehot_err  = 0;
    int n;

    logic [5:0] trace [0:199];

    button_conditioner #(
        .DEBOUNCE_CYCLES     (DB),
        .LONG_PRESS_CYCLES   (LP),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_PERIOD_CYCLES(RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_c_raw     (btn_c_raw),
        .btn_u_raw     (btn_u_raw),
        .btn_d_raw     (btn_d_raw),
        .btn_l_raw     (btn_l_raw),
        .btn_r_raw     (btn_r_raw),
        .button_c_short(button_c_short),
        .button_c_long (button_c_long),
        .button_u      (button_u),
        .button_d      (button_d),
        .button_l      (button_l),
        .button_r      (button_r),
        .btn_level_o   (btn_level_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [5:0] cmd_now();
        return {button_c_short, button_c_long, button_u, button_d, button_l, button_r};
    endfunction

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // trace[base+i] holds the outputs registered at edge i+1 after the call point.
    task automatic collect(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tick();
            trace[base + i] = cmd_now();
            if (!$onehot0(cmd_now())) onehot_err++;
        end
    endtask

    function automatic int count_pulses(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            if (trace[i] != 6'b0) c++;
        end
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (cmd_now() !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_cmd: got %b expected %b", cmd_now(), 6'b0);
        end
        vectors++;
        if (btn_level_o !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_level: got %b expected %b", btn_level_o, 5'b0);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (cmd_now() !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_release_cmd: got %b expected %b", cmd_now(), 6'b0);
        end
        repeat (4) tick();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            btn_u_raw = ~btn_u_raw;
            collect(2 * i, 2);
        end
        btn_u_raw = 1'b0;
        collect(20, 10);
        n = count_pulses(0, 29);
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL bounce_pulses: got %0d expected 0", n);
        end
        vectors++;
        if (btn_level_o !== 5'b0) begin
            miscompares++;
            $display("FAIL bounce_level: got %b expected %b", btn_level_o, 5'b0);
        end
    endtask

    task automatic test_short_press();
        btn_c_raw = 1'b1;
        collect(0, 10);
        vectors++;
        if (btn_level_o !== 5'b10000) begin
            miscompares++;
            $display("FAIL short_level_held: got %b expected %b", btn_level_o, 5'b10000);
        end
        btn_c_raw = 1'b0;
        collect(10, 20);
        vectors++;
        if (trace[16] !== P_SHORT) begin
            miscompares++;
            $display("FAIL short_pulse_edge17: got %b expected %b", trace[16], P_SHORT);
        end
        n = count_pulses(0, 29);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL short_pulse_count: got %0d expected 1", n);
        end
    endtask

    task automatic test_long_press();
        btn_c_raw = 1'b1;
        collect(0, 40);
        btn_c_raw = 1'b0;
        collect(40, 20);
        vectors++;
        if (trace[26] !== P_LONG) begin
            miscompares++;
            $display("FAIL long_pulse_edge27: got %b expected %b", trace[26], P_LONG);
        end
        n = count_pulses(0, 59);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL long_pulse_count: got %0d expected 1", n);
        end
        vectors++;
        if (btn_level_o !== 5'b0) begin
            miscompares++;
            $display("FAIL long_level_after: got %b expected %b", btn_level_o, 5'b0);
        end
    endtask

    task automatic test_contention();
        onehot_err = 0;
        btn_c_raw = 1'b1;
        collect(0, 20);
        btn_u_raw = 1'b1;
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        collect(20, 20);
        vectors++;
        if (btn_level_o !== 5'b11011) begin
            miscompares++;
            $display("FAIL contention_level: got %b expected %b", btn_level_o, 5'b11011);
        end
        btn_c_raw = 1'b0;
        btn_u_raw = 1'b0;
        btn_l_raw = 1'b0;
        btn_r_raw = 1'b0;
        collect(40, 20);
        vectors++;
        if ({trace[26], trace[27], trace[28], trace[29]} !== {P_LONG, P_U, P_L, P_R}) begin
            miscompares++;
            $display("FAIL contention_order: got %b %b %b %b expected %b %b %b %b",
                     trace[26], trace[27], trace[28], trace[29], P_LONG, P_U, P_L, P_R);
        end
        n = count_pulses(0, 59);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL contention_count: got %0d expected 4", n);
        end
        vectors++;
        if (onehot_err !== 0) begin
            miscompares++;
            $display("FAIL contention_onehot: got %0d violations expected 0", onehot_err);
        end
    endtask

    task automatic test_autorepeat();
        btn_r_raw = 1'b1;
        collect(0, 60);
        btn_r_raw = 1'b0;
        collect(60, 20);
        vectors++;
        if (trace[6] !== P_R) begin
            miscompares++;
            $display("FAIL repeat_first_edge7: got %b expected %b", trace[6], P_R);
        end
`ifdef BUTTON_AUTOREPEAT_EN
        vectors++;
        if (trace[35] !== P_R) begin
            miscompares++;
            $display("FAIL repeat_edge36: got %b expected %b", trace[35], P_R);
        end
        vectors++;
        if (trace[45] !== P_R) begin
            miscompares++;
            $display("FAIL repeat_edge46: got %b expected %b", trace[45], P_R);
        end
        n = count_pulses(7, 34);
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL repeat_gap: got %0d expected 0", n);
        end
        n = count_pulses(0, 54);
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL repeat_count: got %0d expected 3", n);
        end
`else
        n = count_pulses(0, 79);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL norepeat_count: got %0d expected 1", n);
        end
`endif
    endtask

    task automatic test_reset_mid_press();
        btn_c_raw = 1'b1;
        collect(0, 12);
        rst = 1'b0;
        collect(12, 3);
        n = count_pulses(12, 14);
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL midreset_pulses: got %0d expected 0", n);
        end
        vectors++;
        if (btn_level_o !== 5'b0) begin
            miscompares++;
            $display("FAIL midreset_level: got %b expected %b", btn_level_o, 5'b0);
        end
        rst = 1'b1;
        collect(15, 10);
        vectors++;
        if (btn_level_o !== 5'b10000) begin
            miscompares++;
            $display("FAIL midreset_relevel: got %b expected %b", btn_level_o, 5'b10000);
        end
        btn_c_raw = 1'b0;
        collect(25, 15);
        vectors++;
        if (trace[31] !== P_SHORT) begin
            miscompares++;
            $display("FAIL midreset_short_edge32: got %b expected %b", trace[31], P_SHORT);
        end
        n = count_pulses(0, 39);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d expected 1", n);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_press();
        test_long_press();
        test_contention();
        test_autorepeat();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
